// File: rtl/morse_char_decoder.sv
// Morse character decoder: classifies high runs as dots/dashes and emits code/len on a character space.
// Optional target comparator and match port are enabled by defining MORSE_MATCH_EN.
module morse_char_decoder #(
  parameter int DOT_LEN   = 1,
  parameter int DASH_LEN  = 3,
  parameter int SPACE_LEN = 3,
  parameter int MAX_SYMS  = 5,
  parameter logic [MAX_SYMS-1:0] TARGET_CODE = 5'b00111,
  parameter int TARGET_LEN = 3,
  localparam int LEN_W = $clog2(MAX_SYMS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in,
  output logic                cb,
  output logic                is,
  output logic                err,
  output logic [MAX_SYMS-1:0] code,
  output logic [LEN_W-1:0]    len
`ifdef MORSE_MATCH_EN
  ,
  output logic                match
`endif
);

  // Run counters saturate one past the longest legal run so over-long runs stay detectable.
  localparam int SAT   = ((DASH_LEN > SPACE_LEN) ? DASH_LEN : SPACE_LEN) + 1;
  localparam int CNT_W = $clog2(SAT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    GAP   = 2'd2,
    ERROR = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0]     lo_cnt_q, lo_cnt_d;
  logic [LEN_W-1:0]     sym_cnt_q, sym_cnt_d;
  logic [MAX_SYMS-1:0]  shift_q, shift_d;
  logic                 cb_q, cb_d;
  logic                 is_q, is_d;
  logic                 err_q, err_d;
  logic [MAX_SYMS-1:0]  code_q, code_d;
  logic [LEN_W-1:0]     len_q, len_d;

  logic [CNT_W-1:0]     hi_inc, lo_inc;
  logic                 sym_valid, sym_bit;

  assign hi_inc = (hi_cnt_q == CNT_W'(SAT)) ? hi_cnt_q : hi_cnt_q + CNT_W'(1);
  assign lo_inc = (lo_cnt_q == CNT_W'(SAT)) ? lo_cnt_q : lo_cnt_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    hi_cnt_d  = hi_cnt_q;
    lo_cnt_d  = lo_cnt_q;
    sym_cnt_d = sym_cnt_q;
    shift_d   = shift_q;
    is_d      = 1'b0;
    err_d     = 1'b0;
    code_d    = code_q;
    len_d     = len_q;
    sym_valid = (hi_cnt_q == CNT_W'(DOT_LEN)) || (hi_cnt_q == CNT_W'(DASH_LEN));
    sym_bit   = (hi_cnt_q == CNT_W'(DASH_LEN));

    case (state_q)
      IDLE: begin
        if (in) begin
          state_d   = MARK;
          hi_cnt_d  = CNT_W'(1);
          lo_cnt_d  = '0;
          sym_cnt_d = '0;
          shift_d   = '0;
        end else begin
          lo_cnt_d = lo_inc;
        end
      end
      MARK: begin
        if (in) begin
          hi_cnt_d = hi_inc;
          if (hi_inc > CNT_W'(DASH_LEN)) begin
            state_d  = ERROR;
            err_d    = 1'b1;
            lo_cnt_d = '0;
          end
        end else begin
          // The terminating low already counts toward the following space.
          hi_cnt_d = '0;
          lo_cnt_d = CNT_W'(1);
          if (!sym_valid || (sym_cnt_q == LEN_W'(MAX_SYMS))) begin
            state_d = ERROR;
            err_d   = 1'b1;
          end else begin
            state_d   = GAP;
            shift_d   = (shift_q << 1) | MAX_SYMS'(sym_bit);
            sym_cnt_d = sym_cnt_q + LEN_W'(1);
          end
        end
      end
      GAP: begin
        if (in) begin
          state_d  = MARK;
          hi_cnt_d = CNT_W'(1);
          lo_cnt_d = '0;
        end else begin
          lo_cnt_d = lo_inc;
          if (lo_inc == CNT_W'(SPACE_LEN)) begin
            state_d = IDLE;
            is_d    = 1'b1;
            code_d  = shift_q;
            len_d   = sym_cnt_q;
          end
        end
      end
      ERROR: begin
        hi_cnt_d = '0;
        if (in) begin
          lo_cnt_d = '0;
        end else begin
          lo_cnt_d = lo_inc;
          if (lo_inc == CNT_W'(SPACE_LEN)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    cb_d = (state_d == MARK) || (state_d == GAP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      hi_cnt_q  <= '0;
      lo_cnt_q  <= '0;
      sym_cnt_q <= '0;
      shift_q   <= '0;
      cb_q      <= 1'b0;
      is_q      <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= '0;
      len_q     <= '0;
    end else begin
      state_q   <= state_d;
      hi_cnt_q  <= hi_cnt_d;
      lo_cnt_q  <= lo_cnt_d;
      sym_cnt_q <= sym_cnt_d;
      shift_q   <= shift_d;
      cb_q      <= cb_d;
      is_q      <= is_d;
      err_q     <= err_d;
      code_q    <= code_d;
      len_q     <= len_d;
    end
  end

  assign cb   = cb_q;
  assign is   = is_q;
  assign err  = err_q;
  assign code = code_q;
  assign len  = len_q;

`ifdef MORSE_MATCH_EN
  logic match_q, match_d;

  always_comb begin
    match_d = is_d && (len_d == LEN_W'(TARGET_LEN)) && (code_d == TARGET_CODE);
  end

  always_ff @(posedge clk) begin
    if (rst) match_q <= 1'b0;
    else     match_q <= match_d;
  end

  assign match = match_q;
`endif

endmodule

// File: tb/tb_morse_char_decoder.sv
// Bench for morse_char_decoder: directed spec sequences plus random run-length stimulus vs a run-length model.
module tb_morse_char_decoder;
  localparam int DOT_LEN    = 1;
  localparam int DASH_LEN   = 3;
  localparam int SPACE_LEN  = 3;
  localparam int MAX_SYMS   = 5;
  localparam int TARGET_CODE = 7;
  localparam int TARGET_LEN  = 3;
  localparam int LEN_W      = $clog2(MAX_SYMS + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in  = 1'b0;
  logic cb, is, err;
  logic [MAX_SYMS-1:0] code;
  logic [LEN_W-1:0]    len;
  logic                match_obs;

  int checks = 0;
  int errors = 0;
  string phase = "init";

  morse_char_decoder dut (
    .clk  (clk),
    .rst  (rst),
    .in   (in),
    .cb   (cb),
    .is   (is),
    .err  (err),
    .code (code),
    .len  (len)
`ifdef MORSE_MATCH_EN
    ,
    .match(match_obs)
`endif
  );

`ifndef MORSE_MATCH_EN
  assign match_obs = 1'b0;
`endif

  always #5 clk = ~clk;

  // Reference model: tracks run lengths and a queue of received symbols.
  int  m_hi, m_lo;
  bit  m_active, m_bad;
  bit  m_syms[$];
  int  e_code, e_len;
  bit  e_cb, e_is, e_err, e_match;

  task automatic model_reset();
    m_hi = 0; m_lo = 0; m_active = 0; m_bad = 0;
    m_syms.delete();
    e_code = 0; e_len = 0; e_cb = 0; e_is = 0; e_err = 0; e_match = 0;
  endtask

  task automatic model_step(input bit b);
    e_is = 0; e_err = 0; e_match = 0;
    if (b) begin
      if (!m_active && !m_bad) begin
        m_active = 1; m_syms.delete(); m_hi = 0;
      end
      m_hi++;
      m_lo = 0;
      if (m_active && m_hi > DASH_LEN) begin
        e_err = 1; m_active = 0; m_bad = 1;
      end
    end else begin
      if (m_active && m_hi > 0) begin
        if ((m_hi != DOT_LEN && m_hi != DASH_LEN) || m_syms.size() == MAX_SYMS) begin
          e_err = 1; m_active = 0; m_bad = 1;
        end else begin
          m_syms.push_back(m_hi == DASH_LEN);
        end
      end
      m_hi = 0;
      m_lo++;
      if (m_active && m_lo == SPACE_LEN) begin
        e_is = 1;
        e_code = 0;
        foreach (m_syms[i]) e_code = e_code * 2 + int'(m_syms[i]);
        e_len = m_syms.size();
        m_active = 0;
`ifdef MORSE_MATCH_EN
        e_match = (e_len == TARGET_LEN) && (e_code == TARGET_CODE);
`endif
      end else if (m_bad && m_lo == SPACE_LEN) begin
        m_bad = 0;
      end
    end
    e_cb = m_active;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %0h expected %0h at %0t", phase, tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("cb",    int'(cb),        int'(e_cb));
    check("is",    int'(is),        int'(e_is));
    check("err",   int'(err),       int'(e_err));
    check("code",  int'(code),      e_code);
    check("len",   int'(len),       e_len);
    check("match", int'(match_obs), int'(e_match));
  endtask

  task automatic step(input bit b);
    in = b;
    @(posedge clk);
    model_step(b);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in  = 1'($urandom_range(0, 1));
    @(posedge clk);
    model_reset();
    #1;
    check_all();
    rst = 1'b0;
  endtask

  task automatic run(input bit b, input int n);
    for (int i = 0; i < n; i++) step(b);
  endtask

  initial begin
    model_reset();
    phase = "reset";
    do_reset();
    do_reset();

    phase = "O";
    run(1, 3); run(0, 1); run(1, 3); run(0, 1); run(1, 3); run(0, 3);

    phase = "A";
    run(1, 1); run(0, 1); run(1, 3); run(0, 3); run(0, 4);

    phase = "bad_run";
    run(1, 2); run(0, 3); run(1, 1); run(0, 3);

    phase = "overflow";
    for (int i = 0; i < 6; i++) begin run(1, 1); run(0, 1); end
    run(0, 3);
    for (int i = 0; i < 5; i++) begin run(1, 1); run(0, 1); end
    run(0, 2);

    phase = "long_mark";
    run(1, 4); run(0, 3); run(1, 3); run(0, 3);

    phase = "rst_mid";
    run(1, 3); run(0, 1); run(1, 1);
    do_reset();
    run(1, 1); run(0, 3);

    phase = "random";
    for (int c = 0; c < 400; c++) begin
      int nsym;
      nsym = $urandom_range(1, MAX_SYMS + 1);
      for (int s = 0; s < nsym; s++) begin
        int ml;
        if ($urandom_range(0, 9) < 8) ml = ($urandom_range(0, 1) != 0) ? DASH_LEN : DOT_LEN;
        else ml = $urandom_range(2, 5);
        run(1, ml);
        if (s != nsym - 1) run(0, ($urandom_range(0, 7) == 0) ? 2 : 1);
      end
      run(0, $urandom_range(2, 6));
      if ($urandom_range(0, 49) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
